// File: rtl/wl_seq_pkg.sv
// Shared types and width helpers for the word-line sequencer.
// Contents: wl_seq_state_t FSM encoding, row_w() row index width, cnt_w() phase counter width.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 50
`endif

package wl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    WL   = 2'd2,
    DONE = 2'd3
  } wl_seq_state_t;

  // Row index width; a single-row array still needs one bit.
  function automatic int unsigned row_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold max(a, b); at least one bit.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/wl_seq_if.sv
// Request handshake plus decoder/sampler outputs of the word-line sequencer.
// master: requester side (drives req_*); slave: sequencer side (drives everything else).
interface wl_seq_if #(
  parameter int unsigned ROW_W = wl_seq_pkg::row_w(`ARRAY_SIZE)
);
  logic             req_valid;
  logic             req_ready;
  logic [ROW_W-1:0] req_row;
  logic             req_sweep;
  logic             address_enable;
  logic [ROW_W-1:0] WL_num;
  logic             prechargeb;
  logic             row_strobe;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_row, req_sweep,
    input  req_ready, address_enable, WL_num, prechargeb, row_strobe, done, err
  );

  modport slave (
    input  req_valid, req_row, req_sweep,
    output req_ready, address_enable, WL_num, prechargeb, row_strobe, done, err
  );
endinterface

// File: rtl/phase_counter.sv
// Loadable down-counter with zero flag, shared by the precharge and word-line phases.
// Ports: clk, rst_n, load/load_val (load wins), dec (saturates at 0), count, zero_c.
module phase_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  assign zero_c = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/wl_sequencer.sv
// Row-access sequencer feeding the word-line decoder: per row a precharge phase
// then a word-line phase, for a single row or a full 0..ARRAY_SIZE-1 sweep.
// Ports: clk, rst_n (async, active low), bus (wl_seq_if.slave: req_valid/ready/row/sweep,
// address_enable, WL_num, prechargeb, row_strobe, done, err).
module wl_sequencer
  import wl_seq_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = `ARRAY_SIZE,
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned WL_CYCLES  = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  wl_seq_if.slave  bus
);

  localparam int unsigned ROW_W = row_w(ARRAY_SIZE);
  localparam int unsigned CW    = cnt_w(PRE_CYCLES, WL_CYCLES);

  wl_seq_state_t   state;
  logic            sweep;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            cnt_load;
  logic            cnt_dec;
  logic [CW-1:0]   cnt_val;
  logic            out_of_range;
  logic            last_row;

  assign bus.req_ready = (state == IDLE);

  assign out_of_range = !bus.req_sweep && (32'(bus.req_row) >= 32'(ARRAY_SIZE));
  assign last_row     = !sweep || (32'(bus.WL_num) >= 32'(ARRAY_SIZE - 1));

  // Counter control: reload on every phase entry, count down inside a phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = CW'(PRE_CYCLES - 1);
    case (state)
      IDLE: cnt_load = bus.req_valid && !out_of_range;
      PRE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(WL_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WL: begin
        if (cnt_zero) cnt_load = !last_row;
        else          cnt_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  phase_counter #(.W(CW)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero_c   (cnt_zero)
  );

  // FSM with registered outputs; outputs are set on the edge entering each phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      sweep              <= 1'b0;
      bus.address_enable <= 1'b0;
      bus.prechargeb     <= 1'b1;
      bus.WL_num         <= '0;
      bus.row_strobe     <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
    end else begin
      bus.row_strobe <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sweep      <= bus.req_sweep;
            bus.WL_num <= bus.req_sweep ? '0 : bus.req_row;
            if (out_of_range) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              state          <= PRE;
              bus.prechargeb <= 1'b0;
            end
          end
        end
        PRE: begin
          if (cnt_zero) begin
            state              <= WL;
            bus.prechargeb     <= 1'b1;
            bus.address_enable <= 1'b1;
            // Single-cycle WL phase: its first cycle is also its last.
            bus.row_strobe     <= (WL_CYCLES == 1);
          end
        end
        WL: begin
          if (cnt_zero) begin
            bus.address_enable <= 1'b0;
            if (!last_row) begin
              bus.WL_num     <= bus.WL_num + ROW_W'(1);
              bus.prechargeb <= 1'b0;
              state          <= PRE;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end else begin
            // Strobe is registered, so raise it one cycle ahead of the last WL cycle.
            bus.row_strobe <= (cnt == CW'(1));
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wl_sequencer.sv
// Self-checking bench for wl_sequencer: directed steps plus an event scoreboard
// (expected strobes/done pushed at request time, popped as the DUT pulses).
module tb_wl_sequencer;

  localparam int unsigned N = 50;

  typedef struct {
    int stamp;
    bit is_done;
    int row;
    bit err;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   viol = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  wl_seq_if bus_a ();
  wl_seq_if bus_b ();

  wl_sequencer #(.PRE_CYCLES(2), .WL_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  wl_sequencer #(.PRE_CYCLES(1), .WL_CYCLES(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected pulses of one request; c0 is the cyc stamp of cycle 1 after accept.
  task automatic push_req(input int which, input int c0, input bit sweep, input int row,
                          input int p, input int w);
    ev_t e;
    int  nrows;
    if (!sweep && row >= int'(N)) begin
      e = '{stamp: c0, is_done: 1'b1, row: 0, err: 1'b1};
      if (which == 0) qa.push_back(e); else qb.push_back(e);
      return;
    end
    nrows = sweep ? int'(N) : 1;
    for (int k = 1; k <= nrows; k++) begin
      e = '{stamp: c0 + k * (p + w) - 1, is_done: 1'b0, row: sweep ? k - 1 : row, err: 1'b0};
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
    e = '{stamp: c0 + nrows * (p + w), is_done: 1'b1, row: 0, err: 1'b0};
    if (which == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // Pop and compare one expected event whenever a DUT pulses.
  task automatic mon(input int which, input logic strobe, input logic done, input logic err,
                     input logic [5:0] row);
    ev_t e;
    int  sz;
    if (!(strobe || done || err)) return;
    sz = (which == 0) ? qa.size() : qb.size();
    chk(which == 0 ? "a_event_expected" : "b_event_expected", 32'(sz > 0), 1);
    if (sz == 0) return;
    if (which == 0) e = qa.pop_front(); else e = qb.pop_front();
    chk("evt_cycle", cyc, e.stamp);
    chk("evt_done", done, e.is_done);
    chk("evt_strobe", strobe, !e.is_done);
    chk("evt_err", err, e.err);
    if (!e.is_done) chk("evt_row", row, e.row);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus_a.row_strobe, bus_a.done, bus_a.err, bus_a.WL_num);
      mon(1, bus_b.row_strobe, bus_b.done, bus_b.err, bus_b.WL_num);
      if (bus_a.address_enable && !bus_a.prechargeb) viol++;
      if (bus_b.address_enable && !bus_b.prechargeb) viol++;
    end
  end

  // Present a request in the cycle before the accept edge; returns at cycle 1.
  task automatic send(input int which, input bit sweep, input int row, input bit hold,
                      output int c0);
    @(negedge clk);
    if (which == 0) begin
      chk("a_ready_before_req", bus_a.req_ready, 1);
      bus_a.req_valid = 1'b1;
      bus_a.req_sweep = sweep;
      bus_a.req_row   = 6'(row);
    end else begin
      chk("b_ready_before_req", bus_b.req_ready, 1);
      bus_b.req_valid = 1'b1;
      bus_b.req_sweep = sweep;
      bus_b.req_row   = 6'(row);
    end
    c0 = cyc + 1;
    if (which == 0) push_req(0, c0, sweep, row, 2, 1);
    else            push_req(1, c0, sweep, row, 1, 3);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      if (which == 0) bus_a.req_valid = 1'b0; else bus_b.req_valid = 1'b0;
    end
  endtask

  task automatic drain(input int which, input int budget);
    int sz;
    for (int i = 0; i < budget; i++) begin
      sz = (which == 0) ? qa.size() : qb.size();
      if (sz == 0) break;
      @(negedge clk);
    end
    sz = (which == 0) ? qa.size() : qb.size();
    chk(which == 0 ? "a_drain_left" : "b_drain_left", sz, 0);
  endtask

  initial begin
    int c0;
    bus_a.req_valid = 1'b0; bus_a.req_sweep = 1'b0; bus_a.req_row = '0;
    bus_b.req_valid = 1'b0; bus_b.req_sweep = 1'b0; bus_b.req_row = '0;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_ready", bus_a.req_ready, 1);
    chk("rst_prechargeb", bus_a.prechargeb, 1);
    chk("rst_ae", bus_a.address_enable, 0);
    chk("rst_wl_num", bus_a.WL_num, 0);
    chk("rst_strobe", bus_a.row_strobe, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_err", bus_a.err, 0);
    chk("rst_b_ready", bus_b.req_ready, 1);
    chk("rst_b_prechargeb", bus_b.prechargeb, 1);

    // Single row 17.
    send(0, 1'b0, 17, 1'b0, c0);
    chk("r17_c1_pb", bus_a.prechargeb, 0);
    chk("r17_c1_ae", bus_a.address_enable, 0);
    chk("r17_c1_ready", bus_a.req_ready, 0);
    chk("r17_c1_wl", bus_a.WL_num, 17);
    @(negedge clk);
    chk("r17_c2_pb", bus_a.prechargeb, 0);
    @(negedge clk);
    chk("r17_c3_ae", bus_a.address_enable, 1);
    chk("r17_c3_pb", bus_a.prechargeb, 1);
    chk("r17_c3_strobe", bus_a.row_strobe, 1);
    @(negedge clk);
    chk("r17_c4_done", bus_a.done, 1);
    chk("r17_c4_ae", bus_a.address_enable, 0);
    chk("r17_c4_ready", bus_a.req_ready, 0);
    @(negedge clk);
    chk("r17_c5_ready", bus_a.req_ready, 1);
    drain(0, 4);

    // Full sweep.
    send(0, 1'b1, 0, 1'b0, c0);
    drain(0, 200);
    @(negedge clk);
    chk("sweep_wl_hold", bus_a.WL_num, N - 1);
    chk("sweep_ready", bus_a.req_ready, 1);

    // Out-of-range single row.
    send(0, 1'b0, 55, 1'b0, c0);
    chk("oor_done", bus_a.done, 1);
    chk("oor_err", bus_a.err, 1);
    chk("oor_pb", bus_a.prechargeb, 1);
    chk("oor_ae", bus_a.address_enable, 0);
    @(negedge clk);
    chk("oor_ready", bus_a.req_ready, 1);
    chk("oor_err_clr", bus_a.err, 0);
    drain(0, 4);

    // Reset in the middle of row 20 of a sweep.
    send(0, 1'b1, 0, 1'b0, c0);
    repeat (60) @(negedge clk);
    chk("mid_row20", bus_a.WL_num, 20);
    chk("mid_row20_pb", bus_a.prechargeb, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus_a.req_ready, 1);
    chk("arst_pb", bus_a.prechargeb, 1);
    chk("arst_ae", bus_a.address_enable, 0);
    chk("arst_wl", bus_a.WL_num, 0);
    chk("arst_done", bus_a.done, 0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_done", bus_a.done, 0);
    send(0, 1'b0, 5, 1'b0, c0);
    drain(0, 10);
    @(negedge clk);
    chk("post_rst_wl", bus_a.WL_num, 5);

    // PRE=1, WL=3, row 0, request held valid while busy.
    send(1, 1'b0, 0, 1'b1, c0);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("b_busy_ready_c%0d", i), bus_b.req_ready, 0);
      chk($sformatf("b_ae_c%0d", i), bus_b.address_enable, 32'(i >= 2 && i <= 4));
      chk($sformatf("b_strobe_c%0d", i), bus_b.row_strobe, 32'(i == 4));
      @(negedge clk);
    end
    chk("b_ready_back", bus_b.req_ready, 1);
    push_req(1, cyc + 1, 1'b0, 0, 1, 3);
    @(posedge clk);
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    chk("b_second_accept", bus_b.req_ready, 0);
    drain(1, 12);
    @(negedge clk);
    chk("b_idle_end", bus_b.req_ready, 1);

    chk("ae_while_precharge", viol, 0);
    chk("a_queue_empty", qa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wl_sequencer.md
# wl_sequencer

Row-access sequencer directly upstream of the word-line decoder. It accepts single-row or full-sweep requests through a valid/ready handshake. For each row it generates the precharge phase and then the word-line phase, driving the decoder's `address_enable`, `WL_num` and `prechargeb` inputs. It also pulses a per-row strobe that the bit-line sampling logic uses.

## Interface
Parameters:
- `ARRAY_SIZE`, default `` `ARRAY_SIZE `` (50): number of rows; row index width `ROW_W = $clog2(ARRAY_SIZE)`.
- `PRE_CYCLES`, default 2: precharge phase length in clocks. Must be ≥1.
- `WL_CYCLES`, default 1: word-line phase length in clocks. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request (high only in IDLE).
- `req_row`  in  ROW_W  target row; ignored when `req_sweep`=1.
- `req_sweep`  in  1  1 = visit rows 0..ARRAY_SIZE-1 in order.
- `address_enable`  out  1  to decoder; high only in the WL phase.
- `WL_num`  out  ROW_W  to decoder; current row.
- `prechargeb`  out  1  to decoder/array; 0 = precharging.
- `row_strobe`  out  1  one-cycle pulse in the last WL cycle of each row.
- `done`  out  1  one-cycle pulse when the request completes.
- `err`  out  1  one-cycle pulse with `done` for an out-of-range single-row request.

## Operation
- Control is a four-state FSM: IDLE, PRE, WL, DONE.
- All outputs except `req_ready` are registered. `req_ready` = (state==IDLE).
- Reset values:
  - state IDLE
  - `address_enable`=0, `prechargeb`=1, `WL_num`=0
  - `row_strobe`=0, `done`=0, `err`=0
  - phase counter 0, sweep flag 0
- **IDLE.** On `req_valid && req_ready`:
  - Latch the sweep flag.
  - Set `WL_num` = sweep ? 0 : `req_row`.
  - If not sweep and `req_row` ≥ ARRAY_SIZE, go to DONE with `err` set.
  - Otherwise go to PRE with counter = PRE_CYCLES-1.
- **PRE.** `prechargeb`=0, `address_enable`=0. Decrement the counter. At 0, go to WL with counter = WL_CYCLES-1.
- **WL.** `prechargeb`=1, `address_enable`=1. Decrement the counter. At 0:
  - Assert `row_strobe` for that cycle.
  - If sweep and `WL_num` < ARRAY_SIZE-1: increment `WL_num` and go to PRE.
  - Otherwise go to DONE.
- **DONE.** `done`=1 (and `err` if flagged) for one cycle, then go to IDLE.
- **Invariants:**
  - `address_enable`=1 implies `prechargeb`=1. They are never both active.
  - `WL_num` changes only on entry to PRE, never while `address_enable`=1.
  - Sweep wrap-around: after row ARRAY_SIZE-1, go to DONE. `WL_num` is not wrapped to 0 and holds ARRAY_SIZE-1 until the next accept.
- `req_valid` is ignored outside IDLE. No queueing, no abort input.
- Reset mid-operation forces reset values immediately (asynchronously). No `done` is emitted for the aborted request.

## Timing
- Accept at edge 0:
  - PRE occupies cycles 1..PRE_CYCLES.
  - WL occupies the next WL_CYCLES cycles.
  - `done` follows in the cycle after the last WL cycle.
  - `req_ready` rises in the cycle after that.
- Single row: `done` at cycle PRE_CYCLES+WL_CYCLES+1.
- Sweep: `done` at cycle ARRAY_SIZE·(PRE_CYCLES+WL_CYCLES)+1, with exactly ARRAY_SIZE `row_strobe` pulses.
- Out-of-range request: `done` and `err` at cycle 1; no PRE or WL phase.
- Back-to-back requests: minimum gap from one `done` to the next accept is 1 cycle (the IDLE cycle).

## Structure
- Shared package `wl_seq_pkg` holds:
  - state typedef `wl_seq_state_t` {IDLE, PRE, WL, DONE}
  - the `ROW_W` derivation helper
- `ARRAY_SIZE` stays the global macro.
- One sub-module, `phase_counter`: a loadable down-counter with a zero flag, shared by the PRE and WL phases. Its width is clog2 of max(PRE_CYCLES, WL_CYCLES)+1.
- The decoder is instantiated by the parent alongside this block, not inside it.

## Test plan
- Reset, then idle for 5 cycles → `req_ready`=1, `prechargeb`=1, `address_enable`=0, `WL_num`=0, no pulses.
- Single row 17, defaults (PRE=2, WL=1) → `prechargeb` low in cycles 1–2; `address_enable`=1 with `WL_num`=17 and `row_strobe` in cycle 3; `done` in cycle 4; ready again in cycle 5.
- Sweep with ARRAY_SIZE=50 → 50 strobes with `WL_num` 0..49 in order; `done` at cycle 151; `address_enable` never high while `prechargeb`=0.
- Single row 55 → `done` and `err` at cycle 1; no PRE or WL activity.
- Assert `rst_n` low during row 20 of a sweep → all outputs at reset values immediately; no `done`; the next request behaves normally.
- PRE_CYCLES=1, WL_CYCLES=3, row 0, second request held valid during busy → only one accept until `req_ready` returns; strobe in the third WL cycle only.
